// File: rtl/spram_arbiter.sv
// spram_arbiter: shares one single-port RAM between two requesters (A, B).
//
// Round-robin arbitration grants at most one access per clock; read data is
// returned to the requester that issued the read one cycle after its grant,
// qualified by a per-port valid strobe.
//
// Optional feature macro: SPRAM_ARB_INIT_EN
//   defined   - after reset the RAM is zero-filled (one word per cycle) before
//               any requester is served; init_done rises when that finishes.
//   undefined - no init sequencer; init_done is constant 1.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_x, we_x, addr_x, wdata_x    requester x access (held until gnt_x)
//   gnt_x                           access accepted at this edge (combinational)
//   rvalid_x, rdata_x               read result for requester x
//   ram_addr, ram_data, ram_we      to the RAM
//   ram_q                           from the RAM (valid the cycle after address)
//   init_done                       high once requests are being accepted
module spram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  output logic                  gnt_a,
  output logic                  rvalid_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  gnt_b,
  output logic                  rvalid_b,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  init_done
);

  if (DEPTH > (1 << ADDR_WIDTH)) begin : g_depth_check
    $error("DEPTH must not exceed 2**ADDR_WIDTH");
  end

  logic                  arb_en;      // arbitration active (not initialising)
  logic                  init_active; // init sequencer owns the RAM this cycle
  logic [ADDR_WIDTH-1:0] init_addr;

`ifdef SPRAM_ARB_INIT_EN
  typedef enum logic [0:0] {StInit, StArb} state_e;

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StInit: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastAddr) state_d = StArb;
      end
      StArb:   state_d = StArb;
      default: state_d = StInit;
    endcase
  end

  assign arb_en      = (state_q == StArb);
  assign init_active = (state_q == StInit);
  assign init_addr   = cnt_q;
  assign init_done   = arb_en;
`else
  assign arb_en      = 1'b1;
  assign init_active = 1'b0;
  assign init_addr   = '0;
  assign init_done   = 1'b1;
`endif

  // rr_q holds the last-served port: 0 = A, 1 = B. The other port wins a tie.
  logic rr_q, rr_d;
  logic pick_b;
  logic rvalid_a_q, rvalid_b_q;

  assign pick_b = req_b & (~req_a | ~rr_q);
  // Gated by rst_n so no grant is seen while reset is asserted.
  assign gnt_b  = rst_n & arb_en & pick_b;
  assign gnt_a  = rst_n & arb_en & req_a & ~pick_b;

  always_comb begin
    rr_d = rr_q;
    if (gnt_a)      rr_d = 1'b0;
    else if (gnt_b) rr_d = 1'b1;
  end

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_data = '0;
    if (init_active) begin
      ram_we   = rst_n;
      ram_addr = init_addr;
    end else if (gnt_a) begin
      ram_we   = we_a;
      ram_addr = addr_a;
      ram_data = wdata_a;
    end else if (gnt_b) begin
      ram_we   = we_b;
      ram_addr = addr_b;
      ram_data = wdata_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q       <= 1'b0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      rvalid_a_q <= gnt_a & ~we_a;
      rvalid_b_q <= gnt_b & ~we_b;
    end
  end

  assign rvalid_a = rvalid_a_q;
  assign rvalid_b = rvalid_b_q;
  assign rdata_a  = ram_q;
  assign rdata_b  = ram_q;

endmodule

// File: tb/tb_spram_arbiter.sv
module tb_spram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_a, we_a, req_b, we_b;
  logic [5:0] addr_a, addr_b;
  logic [7:0] wdata_a, wdata_b;
  logic       gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [7:0] rdata_a, rdata_b;
  logic [5:0] ram_addr;
  logic [7:0] ram_data, ram_q;
  logic       ram_we, init_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         due;
    logic [7:0] data;
  } exp_t;
  exp_t qa[$];
  exp_t qb[$];

`ifdef SPRAM_ARB_INIT_EN
  localparam logic       ExpInitRst = 1'b0;
  localparam logic [7:0] ExpA0After = 8'h00;  // RAM re-zeroed by the second init
  localparam logic [7:0] ExpB5After = 8'h00;
`else
  localparam logic       ExpInitRst = 1'b1;
  localparam logic [7:0] ExpA0After = 8'h01;
  localparam logic [7:0] ExpB5After = 8'hAA;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spram_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .DEPTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q),
    .init_done(init_done)
  );

  // Single-port RAM: registered address, q valid the cycle after the edge.
  logic [7:0] mem [64];
  logic [5:0] ram_addr_q;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    ram_addr_q <= ram_addr;
  end
  assign ram_q = mem[ram_addr_q];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever a read result is due or presented.
  always @(negedge clk) begin
    if (qa.size() > 0 && qa[0].due <= cyc) begin
      chk("rvalid_a", rvalid_a, 1);
      chk("rdata_a", rdata_a, qa[0].data);
      void'(qa.pop_front());
    end else if (rvalid_a) begin
      chk("unexpected_rvalid_a", rvalid_a, 0);
    end
    if (qb.size() > 0 && qb[0].due <= cyc) begin
      chk("rvalid_b", rvalid_b, 1);
      chk("rdata_b", rdata_b, qb[0].data);
      void'(qb.pop_front());
    end else if (rvalid_b) begin
      chk("unexpected_rvalid_b", rvalid_b, 0);
    end
  end

  // One cycle of stimulus; entered and left at 1 time unit after a rising edge.
  task automatic step(input logic ra, input logic wa, input logic [5:0] aa, input logic [7:0] da,
                      input logic rb, input logic wb, input logic [5:0] ab, input logic [7:0] db,
                      input logic ega, input logic egb, input logic [7:0] xa,
                      input logic [7:0] xb, input bit track = 1'b1);
    logic       e_we;
    logic [5:0] e_addr;
    logic [7:0] e_data;
    req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
    req_b = rb; we_b = wb; addr_b = ab; wdata_b = db;
    @(negedge clk);
    chk("gnt_a", gnt_a, ega);
    chk("gnt_b", gnt_b, egb);
    chk("init_done", init_done, 1);
    e_we   = ega ? wa : (egb ? wb : 1'b0);
    e_addr = ega ? aa : (egb ? ab : 6'd0);
    e_data = ega ? da : (egb ? db : 8'd0);
    chk("ram_we", ram_we, e_we);
    chk("ram_addr", ram_addr, e_addr);
    chk("ram_data", ram_data, e_data);
    if (track && ega && !wa) qa.push_back('{cyc + 1, xa});
    if (track && egb && !wb) qb.push_back('{cyc + 1, xb});
    @(posedge clk); #1;
  endtask

  // Runs the whole zero-fill and checks each init write.
  task automatic init_run();
`ifdef SPRAM_ARB_INIT_EN
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      chk("init_gnt_a", gnt_a, 0);
      chk("init_ram_we", ram_we, 1);
      chk("init_ram_addr", ram_addr, i);
      chk("init_ram_data", ram_data, 0);
      chk("init_done_low", init_done, 0);
      @(posedge clk); #1;
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    req_a = 1'b1; we_a = 1'b1; addr_a = 6'd3; wdata_a = 8'h55;
    req_b = 1'b0; we_b = 1'b0; addr_b = 6'd0; wdata_b = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt_a", gnt_a, 0);
    chk("rst_gnt_b", gnt_b, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_rvalid_a", rvalid_a, 0);
    chk("rst_rvalid_b", rvalid_b, 0);
    chk("rst_init_done", init_done, ExpInitRst);
    @(posedge clk); #1;

`ifdef SPRAM_ARB_INIT_EN
    // A holds a read of 63 from reset release; first an init interrupted at 20.
    we_a = 1'b0; addr_a = 6'd63;
    rst_n = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      chk("pre_ram_addr", ram_addr, i);
      chk("pre_gnt_a", gnt_a, 0);
      if (i < 20) begin
        @(posedge clk); #1;
      end
    end
    rst_n = 1'b0;
    #1;
    chk("midinit_done", init_done, 0);
    chk("midinit_ram_we", ram_we, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    init_run();
    step(1, 0, 63, 0, 0, 0, 0, 0, 1, 0, 8'h00, 0);
`else
    rst_n = 1'b1;
`endif

    // A alone: three writes then three reads.
    step(1, 1, 0, 8'h01, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 1, 1, 8'h02, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 1, 2, 8'h03, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h01, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 8'h02, 0);
    step(1, 0, 2, 0, 0, 0, 0, 0, 1, 0, 8'h03, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Both reading continuously: last served was A, so B, A, B, A.
    step(1, 0, 1, 0, 1, 0, 2, 0, 0, 1, 0, 8'h03);
    step(1, 0, 1, 0, 1, 0, 0, 0, 1, 0, 8'h02, 0);
    step(1, 0, 2, 0, 1, 0, 0, 0, 0, 1, 0, 8'h01);
    step(1, 0, 2, 0, 1, 0, 1, 0, 1, 0, 8'h03, 0);

    // A writes AA to 5, B reads it on the next grant.
    step(1, 1, 5, 8'hAA, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 5, 0, 0, 1, 0, 8'hAA);

    // B read granted, then reset in the cycle its rvalid would be high.
    step(0, 0, 0, 0, 1, 0, 5, 0, 0, 1, 0, 0, 1'b0);
    req_a = 1'b0; req_b = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rvalid_b", rvalid_b, 0);
    chk("rst_mid_gnt_b", gnt_b, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    init_run();
    // rr pointer back to A, so the tie goes to B.
    step(1, 0, 0, 0, 1, 0, 5, 0, 0, 1, 0, ExpB5After);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, ExpA0After, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    chk("sb_a_empty", qa.size(), 0);
    chk("sb_b_empty", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
